// File: rtl/seven_segment_reader.sv
// Recovers per-digit BCD/blank state from a multiplexed, active-low seven-segment bus.
// A {anode, segment} pair must hold for STABLE_CYCLES samples before it is committed.
module seven_segment_reader #(
    parameter  int NUM_DIGITS    = 4,
    parameter  int STABLE_CYCLES = 4,
    localparam int IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
    localparam int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [6:0]              segment,
    input  logic [NUM_DIGITS-1:0]   anode,
    input  logic                    clear_err,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [NUM_DIGITS-1:0]   blank_out,
    output logic [NUM_DIGITS-1:0]   valid_out,
    output logic                    update,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    bad_pattern,
    output logic                    anode_err
);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        HELD
    } state_t;

    state_t                     state;
    logic [CNT_W-1:0]           count;
    logic [6:0]                 seg_q;
    logic [NUM_DIGITS-1:0]      an_q;
    logic [NUM_DIGITS+6:0]      prev_pair;

    logic [NUM_DIGITS+6:0]      pair;
    logic                       changed;
    logic                       one_hot;
    logic                       multi_low;
    logic [IDX_W-1:0]           sel_idx;
    logic [3:0]                 dec_val;
    logic                       dec_digit;
    logic                       dec_blank;
    logic                       start_dwell;
    logic                       commit_now;

    assign pair      = {an_q, seg_q};
    assign changed   = (pair != prev_pair);
    assign one_hot   = $onehot(~an_q);
    assign multi_low = ($countones(~an_q) > 1);

    always_comb begin
        dec_val   = 4'd0;
        dec_digit = 1'b1;
        dec_blank = 1'b0;
        case (seg_q)
            7'b100_0000: dec_val = 4'd0;
            7'b111_1001: dec_val = 4'd1;
            7'b010_0100: dec_val = 4'd2;
            7'b011_0000: dec_val = 4'd3;
            7'b001_1001: dec_val = 4'd4;
            7'b001_0010: dec_val = 4'd5;
            7'b000_0010: dec_val = 4'd6;
            7'b111_1000: dec_val = 4'd7;
            7'b000_0000: dec_val = 4'd8;
            7'b001_1000: dec_val = 4'd9;
            7'b111_1111: begin
                dec_digit = 1'b0;
                dec_blank = 1'b1;
            end
            default: dec_digit = 1'b0;
        endcase
    end

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_q[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    // A new dwell starts whenever a one-hot pair appears from IDLE or replaces a different pair.
    always_comb begin
        start_dwell = one_hot && ((state == IDLE) || changed);
        commit_now  = 1'b0;
        if (one_hot) begin
            if (start_dwell) begin
                commit_now = (STABLE_CYCLES == 1);
            end else if (state == COUNT) begin
                commit_now = (count == CNT_W'(STABLE_CYCLES - 1));
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            seg_q       <= 7'h7F;
            an_q        <= '1;
            prev_pair   <= '1;
            bcd_out     <= '0;
            blank_out   <= '1;
            valid_out   <= '0;
            update      <= 1'b0;
            digit_idx   <= '0;
            bad_pattern <= 1'b0;
            anode_err   <= 1'b0;
        end else begin
            seg_q     <= segment;
            an_q      <= anode;
            prev_pair <= pair;
            update    <= 1'b0;

            // Clearing comes first so a same-cycle error set overrides it.
            if (clear_err) begin
                bad_pattern <= 1'b0;
                anode_err   <= 1'b0;
            end

            if (multi_low) begin
                anode_err <= 1'b1;
                state     <= IDLE;
                count     <= '0;
            end else if (!one_hot) begin
                state <= IDLE;
                count <= '0;
            end else if (start_dwell) begin
                state <= (STABLE_CYCLES == 1) ? HELD : COUNT;
                count <= CNT_W'(1);
            end else if (state == COUNT) begin
                count <= count + 1'b1;
                if (commit_now) begin
                    state <= HELD;
                end
            end

            if (commit_now) begin
                update    <= 1'b1;
                digit_idx <= sel_idx;
                if (dec_digit) begin
                    bcd_out[4*sel_idx +: 4] <= dec_val;
                    blank_out[sel_idx]      <= 1'b0;
                    valid_out[sel_idx]      <= 1'b1;
                end else if (dec_blank) begin
                    blank_out[sel_idx] <= 1'b1;
                    valid_out[sel_idx] <= 1'b1;
                end else begin
                    valid_out[sel_idx] <= 1'b0;
                    bad_pattern        <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_reader.sv
// Directed self-checking bench for seven_segment_reader with hand-computed expectations.
module tb_seven_segment_reader;

    logic        clock;
    logic        reset;
    logic [6:0]  segment;
    logic [3:0]  anode;
    logic        clear_err;
    logic [15:0] bcd_out;
    logic [3:0]  blank_out;
    logic [3:0]  valid_out;
    logic        update;
    logic [1:0]  digit_idx;
    logic        bad_pattern;
    logic        anode_err;

    int errors;
    int checks;
    int cycle;
    int upd_count;
    int last_commit;
    int start;
    logic [1:0]  idx_log [8];
    logic [15:0] snap_bcd;
    logic [3:0]  snap_valid;
    logic [3:0]  snap_blank;

    seven_segment_reader #(
        .NUM_DIGITS(4),
        .STABLE_CYCLES(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .segment(segment),
        .anode(anode),
        .clear_err(clear_err),
        .bcd_out(bcd_out),
        .blank_out(blank_out),
        .valid_out(valid_out),
        .update(update),
        .digit_idx(digit_idx),
        .bad_pattern(bad_pattern),
        .anode_err(anode_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle++;

    // Log every commit pulse half a cycle after the edge that produced it.
    always @(negedge clock) begin
        if (update) begin
            if (upd_count < 8) idx_log[upd_count] = digit_idx;
            upd_count++;
            last_commit = cycle;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] an, input logic [6:0] seg, input int cycles);
        anode   = an;
        segment = seg;
        repeat (cycles) @(posedge clock);
        #1;
    endtask

    task automatic pulseClear();
        clear_err = 1'b1;
        @(posedge clock);
        #1;
        clear_err = 1'b0;
    endtask

    initial begin
        errors = 0; checks = 0; cycle = 0; upd_count = 0; last_commit = -1;
        clock = 1'b0; reset = 1'b1; anode = 4'hF; segment = 7'h7F; clear_err = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        checkOutput("reset_bcd", bcd_out, 16'h0000);
        checkOutput("reset_blank", blank_out, 4'hF);
        checkOutput("reset_valid", valid_out, 4'h0);
        checkOutput("reset_update", update, 1'b0);
        checkOutput("reset_idx", digit_idx, 2'd0);
        checkOutput("reset_bad", bad_pattern, 1'b0);
        checkOutput("reset_anerr", anode_err, 1'b0);

        // Single held digit 5 on digit 0
        upd_count = 0;
        start = cycle;
        applyStimulus(4'b1110, 7'b001_0010, 20);
        checkOutput("hold_updates", upd_count, 1);
        checkOutput("hold_latency", last_commit, start + 5);
        checkOutput("hold_idx", digit_idx, 2'd0);
        checkOutput("hold_bcd0", bcd_out[3:0], 4'd5);
        checkOutput("hold_valid0", valid_out[0], 1'b1);
        checkOutput("hold_blank0", blank_out[0], 1'b0);

        // Short glitch of 8 must be rejected, then 7 commits once
        upd_count = 0;
        applyStimulus(4'b1110, 7'b000_0000, 2);
        start = cycle;
        applyStimulus(4'b1110, 7'b111_1000, 6);
        checkOutput("glitch_updates", upd_count, 1);
        checkOutput("glitch_latency", last_commit, start + 5);
        checkOutput("glitch_bcd0", bcd_out[3:0], 4'd7);

        // Digit 2: value 9, then blank keeps the stored BCD
        applyStimulus(4'hF, 7'h7F, 3);
        applyStimulus(4'b1011, 7'b001_1000, 6);
        checkOutput("d2_bcd9", bcd_out[11:8], 4'd9);
        checkOutput("d2_blank_lo", blank_out[2], 1'b0);
        applyStimulus(4'b1011, 7'h7F, 6);
        checkOutput("d2_blank_hi", blank_out[2], 1'b1);
        checkOutput("d2_blank_valid", valid_out[2], 1'b1);
        checkOutput("d2_bcd_kept", bcd_out[11:8], 4'd9);

        // Digit 1: legal 1, then an undecodable pattern
        applyStimulus(4'b1101, 7'b111_1001, 6);
        checkOutput("d1_bcd1", bcd_out[7:4], 4'd1);
        checkOutput("d1_valid", valid_out[1], 1'b1);
        applyStimulus(4'b1101, 7'b111_1110, 6);
        checkOutput("d1_invalid", valid_out[1], 1'b0);
        checkOutput("d1_bcd_kept", bcd_out[7:4], 4'd1);
        checkOutput("bad_set", bad_pattern, 1'b1);
        applyStimulus(4'hF, 7'h7F, 5);
        checkOutput("bad_sticky", bad_pattern, 1'b1);
        pulseClear();
        checkOutput("bad_cleared", bad_pattern, 1'b0);

        // Clear arriving on the same edge as a bad commit: set wins
        upd_count = 0;
        start = cycle;
        applyStimulus(4'b1101, 7'b111_1110, 4);
        pulseClear();
        checkOutput("bad_set_wins", bad_pattern, 1'b1);
        applyStimulus(4'hF, 7'h7F, 2);
        checkOutput("bad_commit_time", last_commit, start + 5);
        pulseClear();

        // Two anodes low: error, nothing committed
        snap_bcd = bcd_out; snap_valid = valid_out; snap_blank = blank_out;
        upd_count = 0;
        applyStimulus(4'b1100, 7'b001_0010, 10);
        checkOutput("multi_updates", upd_count, 0);
        checkOutput("multi_anerr", anode_err, 1'b1);
        checkOutput("multi_bcd", bcd_out, snap_bcd);
        checkOutput("multi_valid", valid_out, snap_valid);
        checkOutput("multi_blank", blank_out, snap_blank);
        applyStimulus(4'hF, 7'h7F, 3);
        pulseClear();
        checkOutput("anerr_cleared", anode_err, 1'b0);

        // Scan 3,1,4,1 across digits 0..3
        upd_count = 0;
        applyStimulus(4'b1110, 7'b011_0000, 4);
        applyStimulus(4'b1101, 7'b111_1001, 4);
        applyStimulus(4'b1011, 7'b001_1001, 4);
        applyStimulus(4'b0111, 7'b111_1001, 4);
        applyStimulus(4'hF, 7'h7F, 3);
        checkOutput("scan_updates", upd_count, 4);
        checkOutput("scan_idx0", idx_log[0], 2'd0);
        checkOutput("scan_idx1", idx_log[1], 2'd1);
        checkOutput("scan_idx2", idx_log[2], 2'd2);
        checkOutput("scan_idx3", idx_log[3], 2'd3);
        checkOutput("scan_bcd", bcd_out, 16'h1413);
        checkOutput("scan_valid", valid_out, 4'hF);
        checkOutput("scan_blank", blank_out, 4'h0);

        // Reset two samples into a dwell; commit needs four fresh samples afterwards
        upd_count = 0;
        start = cycle;
        anode = 4'b1011;
        segment = 7'b111_1000;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("async_bcd", bcd_out, 16'h0000);
        checkOutput("async_blank", blank_out, 4'hF);
        checkOutput("async_valid", valid_out, 4'h0);
        checkOutput("async_update", update, 1'b0);
        checkOutput("async_idx", digit_idx, 2'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        checkOutput("rst_dwell_updates", upd_count, 1);
        checkOutput("rst_dwell_latency", last_commit, start + 9);
        checkOutput("rst_dwell_bcd2", bcd_out[11:8], 4'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
